fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the MIPS datapath, sitting directly upstream of the main control decoder. Owns the PC, requests instructions from instruction memory over a ready handshake, and holds them in an IF/ID register. That register drives `op_code` to the decoder and `pc_plus4` to the jal link path. It also applies stalls, redirects for taken branches and j/jal, and flushes.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; `imem_addr` is valid while this is high.
- `imem_addr`  out  32  current PC.
- `imem_ready`  in  1  `imem_rdata` is valid this cycle; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  fetched instruction word.
- `stall`  in  1  decode cannot accept; the IF/ID register holds.
- `branch_taken`  in  1  taken branch resolved in EX.
- `branch_target`  in  32  PC for `branch_taken`.
- `jump`  in  1  decoder `j` output for the current IF/ID instruction.
- `instr`  out  32  IF/ID instruction.
- `op_code`  out  6  `instr[31:26]`.
- `pc_plus4`  out  32  PC+4 of the IF/ID instruction.
- `valid`  out  1  IF/ID holds a live instruction.

## Operation
- FSM states: BOOT, FETCH, HELD.
- Reset values:
  - state=BOOT
  - pc=`RESET_PC`
  - `instr`=0
  - `pc_plus4`=0
  - `valid`=0
  - `imem_req`=0
  - skid buffer empty
- BOOT: `imem_req`=0. Moves unconditionally to FETCH on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=pc.
  - On `imem_ready`=1 with `stall`=0: IF/ID ← {rdata, pc+4}, `valid`←1, pc←pc+4.
  - On `imem_ready`=1 with `stall`=1: the word and pc+4 go into the skid buffer, pc←pc+4, state→HELD.
  - On `imem_ready`=0 with `stall`=0: `valid`←0 (bubble).
  - On `imem_ready`=0 with `stall`=1: IF/ID holds.
- HELD: `imem_req`=0 and IF/ID holds. When `stall`=0, IF/ID ← skid buffer, `valid`←1, state→FETCH.
- Jump target = {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - `jump` is honoured only when `valid`=1 and `stall`=0.
- Redirect priority: `branch_taken` > `jump` > sequential. A redirect:
  - overrides `stall` and any same-cycle `imem_ready` data;
  - sets pc←target and discards the skid buffer;
  - sets `instr`←0 and `valid`←0 (flush);
  - sets state→FETCH.
- All PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- `branch_target` is not checked for alignment. Low bits pass through as given.

## Timing
- Fetch latency: request to IF/ID valid is 1 edge after the first `imem_ready`. Zero-wait memory sustains 1 instruction per cycle.
- First `imem_req` is asserted 1 cycle after `rst_n` deasserts.
- A redirect asserted in cycle N puts the target on `imem_addr` in cycle N+1. `valid`=0 in N+1.
- Stall release from HELD: the buffered instruction appears 1 edge later. The next `imem_req` follows in that same cycle.
- `rst_n` assertion mid-fetch: all outputs return to reset values immediately (asynchronously). The pending memory response is ignored.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `fetch_count` and `flush_count` (32 bits each, reset 0, wrapping).
  - `fetch_count` increments on each accepted `imem_ready` word.
  - `flush_count` increments on each redirect cycle.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (R-type 000000, lw, sw, beq, j 000010, jal 000011, addi, andi);
  - `NOP_INSTR`=32'h0;
  - the fetch FSM state enum;
  - default `RESET_PC`.
- One sub-module: `fetch_skid_buf`, a 1-entry instruction + pc_plus4 holding register with load/clear/valid.

## Test plan
- Reset, zero-wait memory returning 32'h8C01_0004 at 0 → `imem_addr` 0, 4, 8 on consecutive cycles; `op_code`=6'b100011 and `pc_plus4`=4 one edge after the first ready.
- `stall` high for 3 cycles while `imem_ready`=1 → one word captured into the skid buffer, `imem_req`=0 in HELD; that word appears on `instr` 1 edge after release, with no duplicate or lost words.
- IF/ID holds 32'h0800_0040 (j) at pc_plus4=32'h0000_0010, `jump`=1 → next `imem_addr`=32'h0000_0100, `valid`=0 for one cycle.
- `branch_taken`=1 with target 32'h0000_0200 in the same cycle as `jump`=1 and `stall`=1 → `imem_addr`=32'h200, flush, skid buffer emptied.
- `imem_ready` low for 4 cycles → `imem_addr` stable, `valid`=0 bubbles; pc at 32'hFFFF_FFFC wraps to 0.
- With `FETCH_PERF_CNT_EN`: 10 fetches and 2 redirects → `fetch_count`=10, `flush_count`=2; `rst_n` pulse mid-run clears both and `valid`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, NOP encoding, fetch FSM states and reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word and its pc_plus4.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_plus4,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc_plus4,
  output logic        full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  // Payload is qualified by full, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      q_instr    <= d_instr;
      q_pc_plus4 <= d_pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: PC, imem handshake, IF/ID register, redirects.
// Optional perf counters fetch_count/flush_count enabled by FETCH_PERF_CNT_EN.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic [31:0] pc_plus4,
  output logic        valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  redirect_pc;
  logic         jump_go;
  logic         redirect;
  logic         accept;
  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc_plus4;
  logic         skid_full;

  assign imem_addr   = pc;
  assign op_code     = instr[31:26];
  assign pc_next     = pc + 32'd4;
  assign jump_go     = jump && valid && !stall;
  assign redirect    = branch_taken || jump_go;
  assign redirect_pc = branch_taken ? branch_target
                                    : {pc_plus4[31:28], instr[25:0], 2'b00};
  // A redirect discards any word returned in the same cycle.
  assign accept      = (state == FETCH) && imem_ready && !redirect;
  assign skid_load   = accept && stall;
  assign skid_clear  = redirect || ((state == HELD) && !stall);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .d_instr    (imem_rdata),
    .d_pc_plus4 (pc_next),
    .q_instr    (skid_instr),
    .q_pc_plus4 (skid_pc_plus4),
    .full       (skid_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'd0;
      valid    <= 1'b0;
      imem_req <= 1'b0;
    end else if (redirect) begin
      state    <= FETCH;
      pc       <= redirect_pc;
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
      imem_req <= 1'b1;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_next;
            if (stall) begin
              state    <= HELD;
              imem_req <= 1'b0;
            end else begin
              instr    <= imem_rdata;
              pc_plus4 <= pc_next;
              valid    <= 1'b1;
            end
          end else if (!stall) begin
            valid <= 1'b0;
          end
        end
        HELD: begin
          if (!stall) begin
            instr    <= skid_instr;
            pc_plus4 <= skid_pc_plus4;
            valid    <= skid_full;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (accept)   fetch_count <= fetch_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit (FETCH_PERF_CNT_EN section optional).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op_code;
  logic [31:0] pc_plus4;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .instr         (instr),
    .op_code       (op_code),
    .pc_plus4      (pc_plus4),
    .valid         (valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .flush_count   (flush_count)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic        c_ins;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NV = 22;
  vec_t vt[NV];

  function automatic vec_t mk(logic rdy, logic stl, logic br, logic [31:0] tgt,
                              logic jmp, logic [31:0] rdata, logic e_req,
                              logic [31:0] e_addr, logic e_vld, logic c_ins,
                              logic [31:0] e_ins, logic [31:0] e_pc4);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.br = br; v.tgt = tgt; v.jmp = jmp; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.c_ins = c_ins;
    v.e_ins = e_ins; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic jmp, input logic [31:0] rdata);
    imem_ready    = rdy;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    jump          = jmp;
    imem_rdata    = rdata;
  endtask

  initial begin
    logic [31:0] ins_e;
    // rdy stl br tgt jmp rdata | req addr vld c_ins ins pc4
    vt[0]  = mk(0,0,0,32'h0,0,32'h0,                0,32'h0,0,1,32'h0,32'h0);
    vt[1]  = mk(1,0,0,32'h0,0,32'h8C01_0004,        1,32'h0,0,1,32'h0,32'h0);
    vt[2]  = mk(1,0,0,32'h0,0,32'h2001_0001,        1,32'h4,1,1,32'h8C01_0004,32'h4);
    vt[3]  = mk(1,1,0,32'h0,0,32'h3021_00FF,        1,32'h8,1,1,32'h2001_0001,32'h8);
    vt[4]  = mk(1,1,0,32'h0,1,32'hDEAD_BEEF,        0,32'hC,1,1,32'h2001_0001,32'h8);
    vt[5]  = mk(0,1,0,32'h0,0,32'h0,                0,32'hC,1,1,32'h2001_0001,32'h8);
    vt[6]  = mk(0,0,0,32'h0,0,32'h0,                0,32'hC,1,1,32'h2001_0001,32'h8);
    vt[7]  = mk(1,0,0,32'h0,0,32'h0800_0040,        1,32'hC,1,1,32'h3021_00FF,32'hC);
    vt[8]  = mk(1,0,0,32'h0,1,32'h1234_5678,        1,32'h10,1,1,32'h0800_0040,32'h10);
    vt[9]  = mk(0,0,0,32'h0,1,32'h0,                1,32'h100,0,1,32'h0,32'h10);
    vt[10] = mk(0,1,0,32'h0,0,32'h0,                1,32'h100,0,1,32'h0,32'h10);
    vt[11] = mk(0,0,0,32'h0,0,32'h0,                1,32'h100,0,1,32'h0,32'h10);
    vt[12] = mk(0,0,0,32'h0,0,32'h0,                1,32'h100,0,1,32'h0,32'h10);
    vt[13] = mk(1,0,0,32'h0,0,32'h1000_0003,        1,32'h100,0,1,32'h0,32'h10);
    vt[14] = mk(1,1,0,32'h0,0,32'h0000_0020,        1,32'h104,1,1,32'h1000_0003,32'h104);
    vt[15] = mk(1,1,1,32'h200,1,32'hCAFE_F00D,      0,32'h108,1,1,32'h1000_0003,32'h104);
    vt[16] = mk(1,0,0,32'h0,0,32'h8C02_0000,        1,32'h200,0,1,32'h0,32'h104);
    vt[17] = mk(1,0,1,32'hFFFF_FFFC,0,32'h1111_1111,1,32'h204,1,1,32'h8C02_0000,32'h204);
    vt[18] = mk(1,0,0,32'h0,0,32'h0C00_0001,        1,32'hFFFF_FFFC,0,1,32'h0,32'h204);
    vt[19] = mk(0,0,0,32'h0,0,32'h0,                1,32'h0,1,1,32'h0C00_0001,32'h0);
    vt[20] = mk(0,0,1,32'h203,0,32'h0,              1,32'h0,0,0,32'h0,32'h0);
    vt[21] = mk(0,0,0,32'h0,0,32'h0,                1,32'h203,0,1,32'h0,32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst req",   {31'h0, imem_req}, 32'h0);
    chk("rst addr",  imem_addr, 32'h0);
    chk("rst valid", {31'h0, valid}, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst pc4",   pc_plus4, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rdy, vt[i].stl, vt[i].br, vt[i].tgt, vt[i].jmp, vt[i].rdata);
      #1;
      chk($sformatf("row%0d req", i),   {31'h0, imem_req}, {31'h0, vt[i].e_req});
      chk($sformatf("row%0d addr", i),  imem_addr, vt[i].e_addr);
      chk($sformatf("row%0d valid", i), {31'h0, valid}, {31'h0, vt[i].e_vld});
      if (vt[i].c_ins) begin
        ins_e = vt[i].e_ins;
        chk($sformatf("row%0d instr", i),  instr, ins_e);
        chk($sformatf("row%0d opcode", i), {26'h0, op_code}, {26'h0, ins_e[31:26]});
        chk($sformatf("row%0d pc4", i),    pc_plus4, vt[i].e_pc4);
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-fetch; response during reset/BOOT is ignored
    drive(1, 0, 0, 32'h0, 0, 32'h5555_5555);
    #2 rst_n = 1'b0;
    #1;
    chk("async req",   {31'h0, imem_req}, 32'h0);
    chk("async addr",  imem_addr, 32'h0);
    chk("async valid", {31'h0, valid}, 32'h0);
    chk("async instr", instr, 32'h0);
    chk("async pc4",   pc_plus4, 32'h0);
    @(negedge clk);
    imem_rdata = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    #1;
    chk("boot req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    #1;
    chk("first req",   {31'h0, imem_req}, 32'h1);
    chk("first addr",  imem_addr, 32'h0);
    chk("first valid", {31'h0, valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("post-rst instr", instr, 32'hFFFF_FFFF);
    chk("post-rst pc4",   pc_plus4, 32'h4);
    chk("post-rst addr",  imem_addr, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 0, 32'h2001_0001);
    repeat (10) @(negedge clk);
    drive(0, 0, 1, 32'h40, 0, 32'h0);
    @(negedge clk);
    branch_target = 32'h80;
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("perf fetch", fetch_count, 32'd10);
    chk("perf flush", flush_count, 32'd2);
    chk("perf addr",  imem_addr, 32'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("perf rst fetch", fetch_count, 32'd0);
    chk("perf rst flush", flush_count, 32'd0);
    chk("perf rst valid", {31'h0, valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
